// File: rtl/vid_timing_pkg.sv
// Shared timing defaults, the per-axis timing description, and the centering
// offset helpers shared by both counter axes.
package vid_timing_pkg;

  localparam int DEF_H_ACTIVE = 288;
  localparam int DEF_H_FP     = 20;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 44;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_V_FP     = 11;
  localparam int DEF_V_SYNC   = 7;
  localparam int DEF_V_BP     = 22;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  typedef logic signed [3:0] ofs_t;

  function automatic int axis_total(axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Largest offset magnitude that keeps sync inside the blanking interval.
  function automatic int ofs_limit(axis_timing_t t);
    return ((t.fp < t.bp) ? t.fp : t.bp) - 1;
  endfunction

  function automatic ofs_t clamp_ofs(ofs_t ofs, int lim);
    int v;
    v = int'(ofs);
    if (v > lim) v = lim;
    if (v < -lim) v = -lim;
    return ofs_t'(v);
  endfunction

endpackage

// File: rtl/sync_axis.sv
// One timing axis: position counter plus registered blank and sync flags.
// Flags follow the counter by one enable; the counter itself moves on ce & step.
module sync_axis
  import vid_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CW     = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          step,
  input  logic          ofs_ld,
  input  logic [3:0]    ofs,
  output logic [CW-1:0] cnt,
  output logic          at_end,
  output logic          act,
  output logic          blk,
  output logic          syn
);

  localparam axis_timing_t TIM = '{ACTIVE, FP, SYNC, BP};
  localparam int TOTAL     = axis_total(TIM);
  localparam int LIM       = ofs_limit(TIM);
  localparam int SYNC_BASE = ACTIVE + FP;

  ofs_t ofs_l;
  int   syn_start;
  logic syn_c;

  assign at_end = (cnt == CW'(TOTAL - 1));
  assign act    = (int'(cnt) < ACTIVE);

  always_comb begin
    syn_start = SYNC_BASE - int'(ofs_l);
    syn_c     = (int'(cnt) >= syn_start) && (int'(cnt) < syn_start + SYNC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ofs_l <= '0;
      blk   <= 1'b1;
      syn   <= 1'b0;
    end else if (ce) begin
      blk <= ~act;
      syn <= syn_c;
      if (step) cnt <= at_end ? '0 : cnt + CW'(1);
      // The offset is only reloaded at the frame boundary so a frame never tears.
      if (ofs_ld) ofs_l <= clamp_ofs(ofs_t'(ofs), LIM);
    end
  end

endmodule

// File: rtl/hv_timing_gen.sv
// Horizontal/vertical video timing generator with centering offsets,
// registered blank/sync/DE, gated pixel output, and line/frame start pulses.
module hv_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int POS_W    = 9,
  parameter int RGB_W    = 12,
  parameter int SYNC_POL = 0
) (
  input  logic             MCLK,
  input  logic             RESET_N,
  input  logic             PCE,
  input  logic [3:0]       HOFS,
  input  logic [3:0]       VOFS,
  input  logic [RGB_W-1:0] iRGB,
  output logic [POS_W-1:0] HPOS,
  output logic [POS_W-1:0] VPOS,
  output logic [RGB_W-1:0] oRGB,
  output logic             HBLK,
  output logic             VBLK,
  output logic             DE,
  output logic             HSYN,
  output logic             VSYN,
  output logic             LSTART,
  output logic             FSTART
);

  localparam int   H_TOTAL = axis_total('{H_ACTIVE, H_FP, H_SYNC, H_BP});
  localparam int   V_TOTAL = axis_total('{V_ACTIVE, V_FP, V_SYNC, V_BP});
  localparam int   H_CW    = $clog2(H_TOTAL);
  localparam int   V_CW    = $clog2(V_TOTAL);
  localparam logic SYN_INV = (SYNC_POL == 0);

  logic [H_CW-1:0] hcnt;
  logic [V_CW-1:0] vcnt;
  logic h_end, v_end, h_act, v_act, h_syn, v_syn;
  logic frame_end;

  assign frame_end = h_end & v_end;

  sync_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(H_CW)
  ) u_h_axis (
    .clk(MCLK), .rst_n(RESET_N), .ce(PCE), .step(1'b1),
    .ofs_ld(frame_end), .ofs(HOFS),
    .cnt(hcnt), .at_end(h_end), .act(h_act), .blk(HBLK), .syn(h_syn)
  );

  sync_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(V_CW)
  ) u_v_axis (
    .clk(MCLK), .rst_n(RESET_N), .ce(PCE), .step(h_end),
    .ofs_ld(frame_end), .ofs(VOFS),
    .cnt(vcnt), .at_end(v_end), .act(v_act), .blk(VBLK), .syn(v_syn)
  );

  assign HPOS = POS_W'(hcnt);
  assign VPOS = POS_W'(vcnt);
  assign HSYN = h_syn ^ SYN_INV;
  assign VSYN = v_syn ^ SYN_INV;

  // Start pulses are qualified by PCE so they stay one MCLK wide at any PCE rate.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DE     <= 1'b0;
      oRGB   <= '0;
      LSTART <= 1'b0;
      FSTART <= 1'b0;
    end else begin
      LSTART <= PCE && (hcnt == '0);
      FSTART <= PCE && (hcnt == '0) && (vcnt == '0);
      if (PCE) begin
        DE   <= h_act & v_act;
        oRGB <= (h_act & v_act) ? iRGB : '0;
      end
    end
  end

endmodule

// File: tb/tb_hv_timing_gen.sv
// Directed bench: a small-timing instance for frame-level behaviour and a
// default-timing instance for line-level behaviour.
module tb_hv_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: H 10/3/4/5 (22), V 4/3/2/4 (13), active-high syncs.
  logic        s_rst = 1'b1, s_pce = 1'b1;
  logic [3:0]  s_hofs = '0, s_vofs = '0;
  logic [11:0] s_irgb = 12'hA5C;
  logic [7:0]  s_hpos, s_vpos;
  logic [11:0] s_orgb;
  logic s_hblk, s_vblk, s_de, s_hsyn, s_vsyn, s_lstart, s_fstart;

  hv_timing_gen #(
    .H_ACTIVE(10), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(4), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .POS_W(8), .RGB_W(12), .SYNC_POL(1)
  ) dut_s (
    .MCLK(clk), .RESET_N(s_rst), .PCE(s_pce), .HOFS(s_hofs), .VOFS(s_vofs),
    .iRGB(s_irgb), .HPOS(s_hpos), .VPOS(s_vpos), .oRGB(s_orgb),
    .HBLK(s_hblk), .VBLK(s_vblk), .DE(s_de), .HSYN(s_hsyn), .VSYN(s_vsyn),
    .LSTART(s_lstart), .FSTART(s_fstart)
  );

  // Default instance.
  logic        d_rst = 1'b1, d_pce = 1'b1;
  logic [3:0]  d_hofs = '0, d_vofs = '0;
  logic [11:0] d_irgb = 12'hFFF;
  logic [8:0]  d_hpos, d_vpos;
  logic [11:0] d_orgb;
  logic d_hblk, d_vblk, d_de, d_hsyn, d_vsyn, d_lstart, d_fstart;

  hv_timing_gen dut_d (
    .MCLK(clk), .RESET_N(d_rst), .PCE(d_pce), .HOFS(d_hofs), .VOFS(d_vofs),
    .iRGB(d_irgb), .HPOS(d_hpos), .VPOS(d_vpos), .oRGB(d_orgb),
    .HBLK(d_hblk), .VBLK(d_vblk), .DE(d_de), .HSYN(d_hsyn), .VSYN(d_vsyn),
    .LSTART(d_lstart), .FSTART(d_fstart)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_fstart(output int ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (s_fstart) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_lstart(output int ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_lstart) begin
        ok = 1;
        break;
      end
    end
  endtask

  // HPOS at which the (active-high) small-instance HSYN is first seen in this line.
  task automatic find_hsyn(output int hpos);
    hpos = -1;
    for (int i = 0; i < 30; i++) begin
      if (s_hsyn) begin
        hpos = int'(s_hpos);
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    int k, hpos, vpos, hblk, vblk, de, hsyn, vsyn, lst, fst;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int cur, ok, hp, vp, w;
    int hold_err, pulse_err, rgb_err, de_err, lrun2, frun2, nf;
    int l_first, l_second, f_first, f_second;
    logic [7:0] prev_h;
    logic prev_l, prev_f;
    int d_first_low, d_low_w, d_in_low, d_l1, d_l2, d_de_cnt;

    // k: PCE edges since reset release; outputs reflect the count at k-1.
    tbl.push_back('{  1,  1, 0, 0, 0, 1, 0, 0, 1, 1});
    tbl.push_back('{  2,  2, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{ 10, 10, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{ 11, 11, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{ 13, 13, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{ 14, 14, 0, 1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{ 17, 17, 0, 1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{ 18, 18, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{ 22,  0, 1, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{ 23,  1, 1, 0, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{ 88,  0, 4, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{ 89,  1, 4, 0, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{154,  0, 7, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{155,  1, 7, 0, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{198,  0, 9, 1, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{199,  1, 9, 0, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{286,  0, 0, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{287,  1, 0, 0, 0, 1, 0, 0, 1, 1});

    #1;
    s_rst = 1'b0;
    d_rst = 1'b0;
    #2;
    chk("rst s_hpos", int'(s_hpos), 0);
    chk("rst s_vpos", int'(s_vpos), 0);
    chk("rst s_hblk", int'(s_hblk), 1);
    chk("rst s_vblk", int'(s_vblk), 1);
    chk("rst s_de", int'(s_de), 0);
    chk("rst s_orgb", int'(s_orgb), 0);
    chk("rst s_hsyn", int'(s_hsyn), 0);
    chk("rst s_vsyn", int'(s_vsyn), 0);
    chk("rst s_lstart", int'(s_lstart), 0);
    chk("rst s_fstart", int'(s_fstart), 0);
    chk("rst d_hsyn", int'(d_hsyn), 1);
    chk("rst d_vsyn", int'(d_vsyn), 1);

    // Table-driven frame walk on the small instance.
    @(negedge clk);
    s_rst = 1'b1;
    cur = 0;
    foreach (tbl[i]) begin
      repeat (tbl[i].k - cur) tick();
      cur = tbl[i].k;
      chk($sformatf("k%0d hpos", cur), int'(s_hpos), tbl[i].hpos);
      chk($sformatf("k%0d vpos", cur), int'(s_vpos), tbl[i].vpos);
      chk($sformatf("k%0d hblk", cur), int'(s_hblk), tbl[i].hblk);
      chk($sformatf("k%0d vblk", cur), int'(s_vblk), tbl[i].vblk);
      chk($sformatf("k%0d de", cur), int'(s_de), tbl[i].de);
      chk($sformatf("k%0d hsyn", cur), int'(s_hsyn), tbl[i].hsyn);
      chk($sformatf("k%0d vsyn", cur), int'(s_vsyn), tbl[i].vsyn);
      chk($sformatf("k%0d lstart", cur), int'(s_lstart), tbl[i].lst);
      chk($sformatf("k%0d fstart", cur), int'(s_fstart), tbl[i].fst);
      chk($sformatf("k%0d orgb", cur), int'(s_orgb), (tbl[i].de != 0) ? 'hA5C : 0);
    end

    // Offsets written mid-frame only take effect from the next frame (clamp +-2).
    repeat (60) tick();
    s_hofs = 4'd3;
    wait_lstart(ok);
    chk("lstart seen", ok, 1);
    find_hsyn(hp);
    chk("hsyn same frame", hp, 14);
    wait_fstart(ok);
    chk("fstart seen 1", ok, 1);
    find_hsyn(hp);
    chk("hsyn hofs +3 clamped", hp, 12);

    s_hofs = 4'b1000;
    s_vofs = 4'd7;
    repeat (40) tick();
    wait_fstart(ok);
    chk("fstart seen 2", ok, 1);
    find_hsyn(hp);
    chk("hsyn hofs -8 clamped", hp, 16);
    hp = -1;
    vp = -1;
    for (int i = 0; i < 300; i++) begin
      if (s_vsyn) begin
        hp = int'(s_hpos);
        vp = int'(s_vpos);
        break;
      end
      tick();
    end
    chk("vsyn start vpos", vp, 5);
    chk("vsyn start hpos", hp, 1);
    w = 0;
    while (s_vsyn && w < 100) begin
      w++;
      tick();
    end
    chk("vsyn width", w, 44);

    s_hofs = 4'hF;
    s_vofs = 4'd0;
    wait_fstart(ok);
    chk("fstart seen 3", ok, 1);
    find_hsyn(hp);
    chk("hsyn hofs -1", hp, 15);

    // Asynchronous reset in the middle of the active area.
    s_hofs = 4'd0;
    wait_fstart(ok);
    repeat (48) tick();
    chk("pre-reset hpos", int'(s_hpos), 5);
    chk("pre-reset de", int'(s_de), 1);
    #2;
    s_rst = 1'b0;
    #1;
    chk("midrst hpos", int'(s_hpos), 0);
    chk("midrst vpos", int'(s_vpos), 0);
    chk("midrst de", int'(s_de), 0);
    chk("midrst hblk", int'(s_hblk), 1);
    chk("midrst vblk", int'(s_vblk), 1);
    chk("midrst orgb", int'(s_orgb), 0);
    @(negedge clk);
    s_rst = 1'b1;
    tick();
    chk("post-rst fstart", int'(s_fstart), 1);
    chk("post-rst hpos", int'(s_hpos), 1);
    chk("post-rst vpos", int'(s_vpos), 0);

    // PCE every 4th MCLK.
    s_pce = 1'b0;
    s_irgb = 12'hFFF;
    s_rst = 1'b0;
    @(negedge clk);
    s_rst = 1'b1;
    hold_err = 0; pulse_err = 0; rgb_err = 0; de_err = 0;
    lrun2 = 0; frun2 = 0; nf = 0;
    l_first = -1; l_second = -1; f_first = -1; f_second = -1;
    prev_h = s_hpos; prev_l = 1'b0; prev_f = 1'b0;
    for (int m = 0; m < 1300; m++) begin
      s_pce = ((m % 4) == 0);
      tick();
      if (!s_pce) begin
        if (s_hpos != prev_h) hold_err++;
        if (s_lstart || s_fstart) pulse_err++;
      end
      if (s_lstart) begin
        if (l_first < 0) l_first = m;
        else if (l_second < 0) l_second = m;
        if (prev_l) lrun2++;
      end
      if (s_fstart) begin
        nf++;
        if (f_first < 0) f_first = m;
        else if (f_second < 0) f_second = m;
        if (prev_f) frun2++;
      end
      if (s_orgb != (s_de ? 12'hFFF : 12'h000)) rgb_err++;
      if (s_de != !(s_hblk || s_vblk)) de_err++;
      prev_h = s_hpos; prev_l = s_lstart; prev_f = s_fstart;
    end
    chk("pce4 first fstart", f_first, 0);
    chk("pce4 line period", l_second - l_first, 88);
    chk("pce4 frame period", f_second - f_first, 1144);
    chk("pce4 fstart count", nf, 2);
    chk("pce4 lstart width", lrun2, 0);
    chk("pce4 fstart width", frun2, 0);
    chk("pce4 hold errors", hold_err, 0);
    chk("pce4 pulse errors", pulse_err, 0);
    chk("pce4 blank rgb errors", rgb_err, 0);
    chk("pce4 de errors", de_err, 0);

    // Default timing: one line and a bit with PCE=1, active-low syncs.
    s_pce = 1'b0;
    d_rst = 1'b1;
    d_first_low = -1; d_low_w = 0; d_in_low = 0; d_l1 = -1; d_l2 = -1; d_de_cnt = 0;
    for (int m = 1; m <= 800; m++) begin
      tick();
      if (!d_hsyn) begin
        if (d_first_low < 0) begin
          d_first_low = int'(d_hpos);
          d_in_low = 1;
        end
        if (d_in_low != 0) d_low_w++;
      end else begin
        d_in_low = 0;
      end
      if (d_lstart) begin
        if (d_l1 < 0) d_l1 = m;
        else if (d_l2 < 0) d_l2 = m;
      end
      if (m <= 384 && d_de) d_de_cnt++;
      if (d_de == 1'b0 && d_orgb != 12'h000) rgb_err++;
      if (m == 384) begin
        chk("dflt wrap hpos", int'(d_hpos), 0);
        chk("dflt wrap vpos", int'(d_vpos), 1);
      end
    end
    chk("dflt hsyn start hpos", d_first_low, 309);
    chk("dflt hsyn width", d_low_w, 32);
    chk("dflt line period", d_l2 - d_l1, 384);
    chk("dflt de per line", d_de_cnt, 288);
    chk("dflt blank rgb errors", rgb_err, 0);
    chk("dflt vsyn inactive", int'(d_vsyn), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
